booth_mul_seq_ctrl: RTL and testbench
=====================================

// Module: booth_mul_seq_ctrl
// PURPOSE
//  Sequencer that feeds the 4x4 sequential Booth multiplier core and consumes its result.
//  - Upstream side: valid/ready handshake accepts one signed operand pair.
//  - Core side: holds ip1/ip2 stable, pulses load, waits the N shift cycles, captures op.
//  - Downstream side: result presented with a valid/ready handshake.
// PARAMETERS
//  N      4   operand width; core product width is 2*N
//  CNT_W  3   width of shift counter; must satisfy 2**CNT_W > N
// PORTS
//  clk        in   1    rising-edge clock, shared with multiplier core
//  rst        in   1    asynchronous, active-high reset
//  in_valid   in   1    operand pair valid
//  in_ready   out  1    controller can accept an operand pair
//  in_a       in   N    multiplicand, two's complement (to core ip1)
//  in_b       in   N    multiplier, two's complement (to core ip2)
//  mul_ip1    out  N    core ip1, registered copy of in_a
//  mul_ip2    out  N    core ip2, registered copy of in_b
//  mul_load   out  1    core load strobe
//  mul_op     in   2N   core product output
//  out_valid  out  1    result valid
//  out_ready  in   1    downstream accepts result
//  out_prod   out  2N   captured product, two's complement
//  chk_err    out  1    only with BOOTH_CTRL_SELFCHECK_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, any state, mid-operation included):
//    - state=IDLE; in_ready=1; out_valid=0; mul_load=0.
//    - mul_ip1, mul_ip2, out_prod and the counter = 0.
//    - An in-flight operation is dropped with no result. Core is re-loaded on the next job.
//  - FSM IDLE -> LOAD -> RUN -> CAPT -> DONE -> IDLE. All outputs are registered.
//    - IDLE: in_ready=1. On in_valid&in_ready, latch in_a/in_b into mul_ip1/mul_ip2, go to LOAD.
//    - LOAD: in_ready=0, mul_load=1 for exactly one cycle; counter <= 0; go to RUN.
//    - RUN: mul_load=0. Counter increments each cycle; after N RUN cycles (counter==N-1) go to CAPT.
//      The core performs its N Booth shift steps on these N edges.
//    - CAPT: out_prod <= mul_op; out_valid <= 1; go to DONE.
//    - DONE: hold out_prod and out_valid=1 until out_ready=1. On out_valid&out_ready:
//      out_valid <= 0, go to IDLE.
//  - Timing:
//    - Latency: accept edge E0; core load at E1; shifts E2..E(N+1); out_valid rises at E(N+2).
//    - Minimum issue interval: N+4 cycles (next accept is one cycle after the output handshake).
//  - mul_ip1/mul_ip2 change only in IDLE on acceptance; stable from LOAD through DONE.
//  - in_valid while busy is ignored: in_ready=0, the operand pair is not consumed, no queueing.
//  - out_ready while out_valid=0 has no effect. out_ready held high completes the handshake on
//    the first DONE cycle.
//  - Arithmetic: the product is whatever the core returns.
//    - Known core limit: in_a = -2**(N-1) gives a wrong result (-8*-8 -> 8'hC0).
//    - The controller does not correct this.
// CONFIGURATION
//  - BOOTH_CTRL_SELFCHECK_EN defined:
//    - Adds port chk_err and a combinational reference $signed(mul_ip1)*$signed(mul_ip2).
//    - In CAPT, chk_err <= 1 if mul_op != reference.
//    - chk_err is sticky until rst; reset value 0.
//  - BOOTH_CTRL_SELFCHECK_EN undefined: no chk_err port and no reference multiplier.
//    All other behaviour is identical.
// TESTING
//  1. rst pulse mid-RUN -> next cycle in_ready=1, out_valid=0, mul_load=0, out_prod=0.
//  2. a=4'd12, b=4'd4, out_ready=1 -> mul_load high 1 cycle after accept;
//     out_valid at E6; out_prod=8'hF0 (-16).
//  3. a=4'd11, b=4'd8 -> out_prod=8'h28 (+40). a=4'd2, b=4'd14 -> out_prod=8'hFC (-4).
//  4. Stall: out_ready=0 for 5 cycles after out_valid -> out_prod/out_valid held,
//     in_ready=0, new in_valid ignored. Then out_ready=1 -> in_ready=1 next cycle.
//  5. Back-to-back: in_valid held high with 3 pairs -> accepts spaced exactly N+4=8 cycles;
//     results in order.
//  6. a=4'd8, b=4'd8 with BOOTH_CTRL_SELFCHECK_EN -> out_prod=8'hC0, chk_err=1 and sticky.
//     a=4'd3, b=4'd5 with SELFCHECK_EN, after reset -> 8'h0F, chk_err stays 0.

Source files
------------

// File: rtl/booth_mul_seq_ctrl_if.sv
// Upstream operand and downstream result handshakes for booth_mul_seq_ctrl.
interface booth_mul_seq_ctrl_if #(
  parameter int N = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_prod;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_prod
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod
  );
endinterface

// File: rtl/booth_mul_seq_ctrl.sv
// Sequencer for the N x N sequential Booth multiplier core: accept, load, run, capture, deliver.
// Optional macro BOOTH_CTRL_SELFCHECK_EN adds chk_err and a reference multiplier.
module booth_mul_seq_ctrl #(
  parameter int N     = 4,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  booth_mul_seq_ctrl_if.slave  bus,
  output logic [N-1:0]         mul_ip1,
  output logic [N-1:0]         mul_ip2,
  output logic                 mul_load,
  input  logic [2*N-1:0]       mul_op
`ifdef BOOTH_CTRL_SELFCHECK_EN
  ,
  output logic                 chk_err
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             in_ready_q, in_ready_nx;
  logic             out_valid_q, out_valid_nx;
  logic [2*N-1:0]   out_prod_q, out_prod_nx;
  logic             load_nx;
  logic [N-1:0]     ip1_nx, ip2_nx;
  logic             op_mismatch;

`ifdef BOOTH_CTRL_SELFCHECK_EN
  logic             chk_nx;
  logic [2*N-1:0]   a_ext, b_ext, ref_prod;

  assign a_ext       = {{N{mul_ip1[N-1]}}, mul_ip1};
  assign b_ext       = {{N{mul_ip2[N-1]}}, mul_ip2};
  assign ref_prod    = a_ext * b_ext;
  assign op_mismatch = (mul_op != ref_prod);
`else
  assign op_mismatch = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_prod  = out_prod_q;

  // Every output is registered: the comb block computes the next value of each register.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    in_ready_nx  = in_ready_q;
    out_valid_nx = out_valid_q;
    out_prod_nx  = out_prod_q;
    load_nx      = 1'b0;
    ip1_nx       = mul_ip1;
    ip2_nx       = mul_ip2;
`ifdef BOOTH_CTRL_SELFCHECK_EN
    chk_nx       = chk_err;
`endif
    case (state)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          ip1_nx      = bus.in_a;
          ip2_nx      = bus.in_b;
          in_ready_nx = 1'b0;
          load_nx     = 1'b1;
          state_nx    = LOAD;
        end
      end
      LOAD: begin
        cnt_nx   = '0;
        state_nx = RUN;
      end
      RUN: begin
        cnt_nx = cnt + CNT_W'(1);
        if (cnt == CNT_W'(N - 1)) state_nx = CAPT;
      end
      CAPT: begin
        out_prod_nx  = mul_op;
        out_valid_nx = 1'b1;
        state_nx     = DONE;
`ifdef BOOTH_CTRL_SELFCHECK_EN
        if (op_mismatch) chk_nx = 1'b1;
`endif
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_nx = 1'b0;
          in_ready_nx  = 1'b1;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_prod_q  <= '0;
      mul_load    <= 1'b0;
      mul_ip1     <= '0;
      mul_ip2     <= '0;
`ifdef BOOTH_CTRL_SELFCHECK_EN
      chk_err     <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      in_ready_q  <= in_ready_nx;
      out_valid_q <= out_valid_nx;
      out_prod_q  <= out_prod_nx;
      mul_load    <= load_nx;
      mul_ip1     <= ip1_nx;
      mul_ip2     <= ip2_nx;
`ifdef BOOTH_CTRL_SELFCHECK_EN
      chk_err     <= chk_nx;
`endif
    end
  end

endmodule

// File: tb/tb_booth_mul_seq_ctrl.sv
// Scoreboard bench for booth_mul_seq_ctrl with a behavioural radix-2 Booth core attached.
module tb_booth_mul_seq_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  booth_mul_seq_ctrl_if #(.N(N)) bus ();
  logic [N-1:0]   mul_ip1, mul_ip2;
  logic           mul_load;
  logic [2*N-1:0] mul_op;
`ifdef BOOTH_CTRL_SELFCHECK_EN
  logic           chk_err;
`endif

  booth_mul_seq_ctrl #(.N(N), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .mul_ip1  (mul_ip1),
    .mul_ip2  (mul_ip2),
    .mul_load (mul_load),
    .mul_op   (mul_op)
`ifdef BOOTH_CTRL_SELFCHECK_EN
    ,
    .chk_err  (chk_err)
`endif
  );

  // Core model: N-bit accumulator, so a multiplicand of -2**(N-1) overflows as in the real core.
  logic signed [N-1:0] ca, cm, ct;
  logic [N-1:0]        cq;
  logic                cq1;
  int                  cc;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ca <= '0; cm <= '0; cq <= '0; cq1 <= 1'b0; cc <= N;
    end else if (mul_load) begin
      ca <= '0; cm <= mul_ip1; cq <= mul_ip2; cq1 <= 1'b0; cc <= 0;
    end else if (cc < N) begin
      ct = ca;
      if ({cq[0], cq1} == 2'b10) ct = ca - cm;
      else if ({cq[0], cq1} == 2'b01) ct = ca + cm;
      ca  <= ct >>> 1;
      cq  <= {ct[0], cq[N-1:1]};
      cq1 <= cq[0];
      cc  <= cc + 1;
    end
  end
  assign mul_op = {ca, cq};

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  logic [2*N-1:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a result is consumed on each cycle where out_valid and out_ready are both high.
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", bus.out_prod);
      end else begin
        logic [2*N-1:0] e;
        e = sb.pop_front();
        if (bus.out_prod !== e) begin
          errors++;
          $display("FAIL out_prod: got %0h expected %0h (t=%0t)", bus.out_prod, e, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2*N-1:0] exp,
                       input bit push, input bit keep, output int acc);
    int n;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      chk("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      acc = -1;
      return;
    end
    tick();
    acc = cyc;
    if (push) sb.push_back(exp);
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (bus.out_valid !== 1'b1) chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  int e0, t0, t1, t2;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
    #12;
    @(negedge clk) rst = 1'b0;
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mul_load", 32'(mul_load), 32'd0);
    chk("rst_out_prod", 32'(bus.out_prod), 32'd0);
    chk("rst_mul_ip1", 32'(mul_ip1), 32'd0);

    // Reset mid-RUN drops the job without a result
    issue(4'd11, 4'd8, 8'h28, 1'b0, 1'b0, e0);
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("midrun_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrun_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrun_mul_load", 32'(mul_load), 32'd0);
    chk("midrun_out_prod", 32'(bus.out_prod), 32'd0);
    chk("midrun_mul_ip1", 32'(mul_ip1), 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (10) tick();
    chk("midrun_no_result", 32'(bus.out_valid), 32'd0);

    // Latency and load strobe
    issue(4'd12, 4'd4, 8'hF0, 1'b1, 1'b0, e0);
    chk("load_high", 32'(mul_load), 32'd1);
    chk("ip1_latched", 32'(mul_ip1), 32'd12);
    chk("ip2_latched", 32'(mul_ip2), 32'd4);
    chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
    tick();
    chk("load_one_cycle", 32'(mul_load), 32'd0);
    wait_out();
    chk("latency", 32'(cyc - e0), 32'd6);
    tick();
    chk("valid_one_cycle", 32'(bus.out_valid), 32'd0);
    chk("ready_after_hs", 32'(bus.in_ready), 32'd1);

    issue(4'd11, 4'd8, 8'h28, 1'b1, 1'b0, e0);
    issue(4'd2, 4'd14, 8'hFC, 1'b1, 1'b0, e0);
    drain();

    // Downstream stall with a competing operand pair offered
    bus.out_ready = 1'b0;
    issue(4'd11, 4'd8, 8'h28, 1'b1, 1'b0, e0);
    wait_out();
    bus.in_valid = 1'b1; bus.in_a = 4'd2; bus.in_b = 4'd14;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_prod", 32'(bus.out_prod), 32'h28);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_ip1", 32'(mul_ip1), 32'd11);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("stall_release_ready", 32'(bus.in_ready), 32'd1);
    chk("stall_release_valid", 32'(bus.out_valid), 32'd0);
    issue(4'd2, 4'd14, 8'hFC, 1'b1, 1'b0, e0);
    drain();

    // Back-to-back with in_valid held
    issue(4'd12, 4'd4, 8'hF0, 1'b1, 1'b1, t0);
    issue(4'd3, 4'd5, 8'h0F, 1'b1, 1'b1, t1);
    issue(4'd2, 4'd14, 8'hFC, 1'b1, 1'b0, t2);
    chk("b2b_gap1", 32'(t1 - t0), 32'd8);
    chk("b2b_gap2", 32'(t2 - t1), 32'd8);
    drain();

    // Core limit: -8 multiplicand is passed through uncorrected
    issue(4'd8, 4'd8, 8'hC0, 1'b1, 1'b0, e0);
    wait_out();
`ifdef BOOTH_CTRL_SELFCHECK_EN
    chk("chk_err_set", 32'(chk_err), 32'd1);
`endif
    drain();
    issue(4'd3, 4'd5, 8'h0F, 1'b1, 1'b0, e0);
    drain();
`ifdef BOOTH_CTRL_SELFCHECK_EN
    chk("chk_err_sticky", 32'(chk_err), 32'd1);
`endif
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    tick();
`ifdef BOOTH_CTRL_SELFCHECK_EN
    chk("chk_err_reset", 32'(chk_err), 32'd0);
`endif
    issue(4'd3, 4'd5, 8'h0F, 1'b1, 1'b0, e0);
    wait_out();
    chk("final_prod", 32'(bus.out_prod), 32'h0F);
`ifdef BOOTH_CTRL_SELFCHECK_EN
    chk("chk_err_clean", 32'(chk_err), 32'd0);
`endif
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
